// File: rtl/hc8_dma_ctrl.sv
// Single-channel memory-to-memory DMA engine: requests the CPU bus, then
// copies one byte per READ/WRITE pair, wrapping both addresses at 16 bits.
module hc8_dma_ctrl (
  input  logic        clk,
  input  logic        nReset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  output logic        nDMA_REQ,
  input  logic        nDMA_ACK,
  output logic [15:0] address_bus,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  ram_wdata,
  output logic        nRAM_RD,
  output logic        nRAM_WR,
  output logic        bus_oe,
  output logic        busy,
  output logic        done,
  output logic [15:0] remaining
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, RELEASE} state_t;

  state_t        state;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic          abort_pend;

  // All outputs are registered alongside the state so they line up with it.
  // ram_wdata doubles as the read-data latch: it is loaded on the READ exit
  // edge and cleared whenever the bus is not being driven.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      src         <= '0;
      dst         <= '0;
      remaining   <= '0;
      abort_pend  <= 1'b0;
      nDMA_REQ    <= 1'b1;
      nRAM_RD     <= 1'b1;
      nRAM_WR     <= 1'b1;
      bus_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      address_bus <= '0;
      ram_wdata   <= '0;
    end else begin
      done        <= 1'b0;
      bus_oe      <= 1'b0;
      nRAM_RD     <= 1'b1;
      nRAM_WR     <= 1'b1;
      address_bus <= '0;
      ram_wdata   <= '0;

      unique case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              src        <= src_addr;
              dst        <= dst_addr;
              remaining  <= length;
              abort_pend <= 1'b0;
              nDMA_REQ   <= 1'b0;
              busy       <= 1'b1;
              state      <= REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end

        REQ: begin
          if (abort || abort_pend) begin
            nDMA_REQ   <= 1'b1;
            done       <= 1'b1;
            abort_pend <= 1'b0;
            state      <= RELEASE;
          end else if (!nDMA_ACK) begin
            bus_oe      <= 1'b1;
            address_bus <= src;
            nRAM_RD     <= 1'b0;
            state       <= READ;
          end
        end

        READ: begin
          // An abort seen here still lets the current byte finish its write.
          abort_pend <= abort_pend | abort;
          if (nDMA_ACK) begin
            state <= REQ;
          end else begin
            bus_oe      <= 1'b1;
            address_bus <= dst;
            ram_wdata   <= ram_rdata;
            nRAM_WR     <= 1'b0;
            state       <= WRITE;
          end
        end

        WRITE: begin
          if (nDMA_ACK) begin
            state <= REQ;
          end else begin
            src       <= src + AW'(1);
            dst       <= dst + AW'(1);
            remaining <= remaining - AW'(1);
            if (remaining == AW'(1) || abort || abort_pend) begin
              nDMA_REQ   <= 1'b1;
              done       <= 1'b1;
              abort_pend <= 1'b0;
              state      <= RELEASE;
            end else begin
              bus_oe      <= 1'b1;
              address_bus <= src + AW'(1);
              nRAM_RD     <= 1'b0;
              state       <= READ;
            end
          end
        end

        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          nDMA_REQ <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc8_dma_ctrl.sv
// Self-checking bench for hc8_dma_ctrl: table of whole transfers against a
// byte-addressed RAM model, plus directed grant-loss, abort and reset cases.
module tb_hc8_dma_ctrl;

  logic        clk = 1'b0;
  logic        nReset;
  logic        start;
  logic        abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        nDMA_REQ;
  logic        nDMA_ACK = 1'b1;
  logic [15:0] address_bus;
  logic [7:0]  ram_rdata;
  logic [7:0]  ram_wdata;
  logic        nRAM_RD;
  logic        nRAM_WR;
  logic        bus_oe;
  logic        busy;
  logic        done;
  logic [15:0] remaining;

  hc8_dma_ctrl dut (
    .clk(clk), .nReset(nReset), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .nDMA_REQ(nDMA_REQ), .nDMA_ACK(nDMA_ACK), .address_bus(address_bus),
    .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .nRAM_RD(nRAM_RD),
    .nRAM_WR(nRAM_WR), .bus_oe(bus_oe), .busy(busy), .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign ram_rdata = mem[address_bus];

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned req_cnt = 0;
  int unsigned ack_delay = 0;
  int unsigned busy_cycles = 0;
  int unsigned done_cnt = 0;
  int unsigned viol_cnt = 0;
  bit          ack_block = 1'b0;
  bit          req_seen = 1'b0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  logic [7:0]  wd_q[$];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return 8'(a[7:0] * 8'd13 + a[15:8] + 8'd5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Mid-cycle monitor, RAM write port and CPU grant model.
  always @(negedge clk) begin
    if (!nRAM_RD) rd_q.push_back(address_bus);
    if (!nRAM_WR) begin
      wr_q.push_back(address_bus);
      wd_q.push_back(ram_wdata);
      if (nReset) mem[address_bus] = ram_wdata;
    end
    if (done) done_cnt++;
    if (busy) busy_cycles++;
    if (!nDMA_REQ) req_seen = 1'b1;
    if ((!nRAM_RD && !nRAM_WR) ||
        (!bus_oe && (!nRAM_RD || !nRAM_WR || address_bus != 16'h0 || ram_wdata != 8'h0)))
      viol_cnt++;
    if (nDMA_REQ) begin
      req_cnt  = 0;
      nDMA_ACK = 1'b1;
    end else begin
      req_cnt++;
      nDMA_ACK = (ack_block || req_cnt <= ack_delay) ? 1'b1 : 1'b0;
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
  endtask

  task automatic clear_logs();
    rd_q.delete(); wr_q.delete(); wd_q.delete();
    done_cnt = 0; busy_cycles = 0; viol_cnt = 0; req_seen = 1'b0;
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                        input int unsigned hold);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    for (int i = 1; i < int'(hold); i++) begin
      @(posedge clk); #1;
      src_addr = 16'hAAAA; dst_addr = 16'hBBBB; length = 16'd9;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((busy || done) && n < 300);
    chk({name, "_timeout"}, 32'(busy || done), 32'd0);
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int unsigned delay;
    int unsigned hold;
    int unsigned exp_busy;
    logic [15:0] exp_rem;
  } vec_t;

  vec_t vecs [5];

  logic [15:0] exp_rd_a [5] = '{16'h6000, 16'h6001, 16'h6001, 16'h6002, 16'h6003};
  logic [15:0] exp_wr_a [5] = '{16'h7000, 16'h7001, 16'h7001, 16'h7002, 16'h7003};

  initial begin
    int bad;
    int n;
    nReset = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;

    vecs[0] = '{16'h1000, 16'h2000, 16'd3, 2, 1, 10, 16'd0};
    vecs[1] = '{16'hFFFF, 16'h0010, 16'd2, 0, 1, 6,  16'd0};
    vecs[2] = '{16'h0100, 16'h0200, 16'd0, 0, 1, 0,  16'd0};
    vecs[3] = '{16'h3000, 16'hFFFE, 16'd4, 1, 2, 11, 16'd0};
    vecs[4] = '{16'h4000, 16'h5000, 16'd1, 5, 1, 9,  16'd0};

    init_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nDMA_REQ", 32'(nDMA_REQ), 32'd1);
    chk("rst_nRAM_RD", 32'(nRAM_RD), 32'd1);
    chk("rst_nRAM_WR", 32'(nRAM_WR), 32'd1);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk("rst_address_bus", 32'(address_bus), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    nReset = 1'b1;

    // Whole transfers from the table
    for (int v = 0; v < 5; v++) begin
      init_mem();
      clear_logs();
      ack_delay = vecs[v].delay;
      launch(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].hold);
      if (vecs[v].len == 16'd0) chk($sformatf("v%0d_done_next", v), 32'(done), 32'd1);
      wait_idle($sformatf("v%0d", v));
      chk($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'd1);
      chk($sformatf("v%0d_busy_cycles", v), 32'(busy_cycles), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_remaining", v), 32'(remaining), 32'(vecs[v].exp_rem));
      chk($sformatf("v%0d_rd_count", v), 32'(rd_q.size()), 32'(vecs[v].len));
      chk($sformatf("v%0d_wr_count", v), 32'(wr_q.size()), 32'(vecs[v].len));
      chk($sformatf("v%0d_req_seen", v), 32'(req_seen), 32'(vecs[v].len != 16'd0));
      chk($sformatf("v%0d_bus_rules", v), 32'(viol_cnt), 32'd0);
      bad = 0;
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        if (k < rd_q.size() && rd_q[k] !== 16'(vecs[v].src + 16'(k))) bad++;
        if (k < wr_q.size() && wr_q[k] !== 16'(vecs[v].dst + 16'(k))) bad++;
        if (k < wd_q.size() && wd_q[k] !== pat(16'(vecs[v].src + 16'(k)))) bad++;
        if (mem[16'(vecs[v].dst + 16'(k))] !== pat(16'(vecs[v].src + 16'(k)))) bad++;
      end
      chk($sformatf("v%0d_copy_errs", v), 32'(bad), 32'd0);
      chk($sformatf("v%0d_past_end", v),
          32'(mem[16'(vecs[v].dst + vecs[v].len)]), 32'(pat(16'(vecs[v].dst + vecs[v].len))));
    end

    // Grant lost during the write of byte 2 of 4
    init_mem(); clear_logs(); ack_delay = 0;
    launch(16'h6000, 16'h7000, 16'd4, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(!nRAM_WR && wr_q.size() == 1) && n < 50);
    chk("gl_reach_write2", 32'(n < 50), 32'd1);
    ack_block = 1'b1;
    @(posedge clk); #1;
    chk("gl_bus_oe", 32'(bus_oe), 32'd0);
    chk("gl_req_held", 32'(nDMA_REQ), 32'd0);
    chk("gl_remaining", 32'(remaining), 32'd3);
    ack_block = 1'b0;
    wait_idle("gl");
    chk("gl_rd_count", 32'(rd_q.size()), 32'd5);
    chk("gl_wr_count", 32'(wr_q.size()), 32'd5);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < rd_q.size() && rd_q[k] !== exp_rd_a[k]) bad++;
      if (k < wr_q.size() && wr_q[k] !== exp_wr_a[k]) bad++;
    end
    for (int k = 0; k < 4; k++)
      if (mem[16'h7000 + 16'(k)] !== pat(16'h6000 + 16'(k))) bad++;
    chk("gl_copy_errs", 32'(bad), 32'd0);
    chk("gl_remaining_end", 32'(remaining), 32'd0);
    chk("gl_done_cnt", 32'(done_cnt), 32'd1);

    // Abort while still waiting for the grant
    init_mem(); clear_logs(); ack_block = 1'b1;
    launch(16'h8000, 16'h9000, 16'd5, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_req_done", 32'(done), 32'd1);
    chk("ab_req_nDMA_REQ", 32'(nDMA_REQ), 32'd1);
    wait_idle("ab_req");
    ack_block = 1'b0;
    chk("ab_req_done_cnt", 32'(done_cnt), 32'd1);
    chk("ab_req_remaining", 32'(remaining), 32'd5);
    chk("ab_req_strobes", 32'(rd_q.size() + wr_q.size()), 32'd0);

    // Abort during the read of byte 1: that byte still completes
    init_mem(); clear_logs(); ack_delay = 0;
    launch(16'hA000, 16'hB000, 16'd5, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (nRAM_RD && n < 50);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle("ab_rd");
    chk("ab_rd_rd_count", 32'(rd_q.size()), 32'd1);
    chk("ab_rd_wr_count", 32'(wr_q.size()), 32'd1);
    chk("ab_rd_remaining", 32'(remaining), 32'd4);
    chk("ab_rd_done_cnt", 32'(done_cnt), 32'd1);
    chk("ab_rd_byte0", 32'(mem[16'hB000]), 32'(pat(16'hA000)));
    chk("ab_rd_byte1", 32'(mem[16'hB001]), 32'(pat(16'hB001)));

    // Reset pulsed in the middle of a write strobe
    init_mem(); clear_logs(); ack_delay = 0;
    launch(16'hC000, 16'hD000, 16'd4, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (nRAM_WR && n < 50);
    #2 nReset = 1'b0;
    #1;
    chk("rs_nRAM_WR", 32'(nRAM_WR), 32'd1);
    chk("rs_nDMA_REQ", 32'(nDMA_REQ), 32'd1);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_remaining", 32'(remaining), 32'd0);
    chk("rs_bus_oe", 32'(bus_oe), 32'd0);
    chk("rs_address_bus", 32'(address_bus), 32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rs_done_cnt", 32'(done_cnt), 32'd0);
    chk("rs_no_write", 32'(mem[16'hD000]), 32'(pat(16'hD000)));
    chk("rs_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
